// File: rtl/tu_pkg.sv
// Shared widths and the lane-byte type for the trigger-unit lane slipper.
package tu_pkg;
   localparam int unsigned LANE_W          = 8;
   localparam int unsigned SLIP_W          = 3;
   localparam int unsigned WRAP_W          = 16;
   localparam int unsigned HOLDOFF_DEFAULT = 4;

   typedef logic [LANE_W-1:0] lane_byte_t;
endpackage

// File: rtl/tu_lane_slip_unit.sv
// One trigger lane: two-stage capture, {cur,prev} window select, slip pointer, holdoff timer.
// Pointer/wrap status ports exist only when TU_LANE_STATUS_EN is defined.
module tu_lane_slip_unit
   import tu_pkg::*;
#(
   parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  lane_byte_t din_i,
   input  logic       din_valid_i,
   input  logic       slip_i,
   input  logic       slip_clr_i,
   output lane_byte_t dout_o,
   output logic       valid_o,
   output logic       busy_o
`ifdef TU_LANE_STATUS_EN
   ,
   output logic [SLIP_W-1:0] pos_o,
   output logic              wrap_o
`endif
);
   localparam int unsigned CNT_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

   lane_byte_t          cur_q, cur_d;
   lane_byte_t          prev_q, prev_d;
   lane_byte_t          dout_q, dout_d;
   logic                v1_q, v1_d;
   logic                v2_q, v2_d;
   logic [SLIP_W-1:0]   pos_q, pos_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*LANE_W-1:0] window;
   logic                busy;
   logic                slip_ok;

   assign busy    = (cnt_q != '0);
   assign slip_ok = slip_i && !busy && !slip_clr_i;

   always_comb begin
      window = {cur_q, prev_q};
      cur_d  = din_valid_i ? din_i : cur_q;
      v1_d   = din_valid_i;
      prev_d = v1_q ? cur_q : prev_q;
      // pointer is sampled here, so a slip lands on the next stage-2 word
      dout_d = v1_q ? window[pos_q +: LANE_W] : dout_q;
      v2_d   = v1_q;
      pos_d  = pos_q;
      cnt_d  = cnt_q;
      if (slip_clr_i) begin
         pos_d = '0;
         cnt_d = '0;
      end else if (slip_ok) begin
         pos_d = pos_q + SLIP_W'(1);
         cnt_d = CNT_W'(HOLDOFF);
      end else if (busy) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cur_q  <= '0;
         prev_q <= '0;
         dout_q <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         pos_q  <= '0;
         cnt_q  <= '0;
      end else begin
         cur_q  <= cur_d;
         prev_q <= prev_d;
         dout_q <= dout_d;
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         pos_q  <= pos_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout_o  = dout_q;
   assign valid_o = v2_q;
   assign busy_o  = busy;
`ifdef TU_LANE_STATUS_EN
   assign pos_o  = pos_q;
   assign wrap_o = slip_ok && (pos_q == '1);
`endif
endmodule

// File: rtl/tu_lane_slipper.sv
// Per-lane fabric bitslip ahead of the trigger-unit bitslip generator.
// TU_LANE_STATUS_EN enables slip_pos / wrap_cnt; otherwise both are tied to zero.
module tu_lane_slipper
   import tu_pkg::*;
#(
   parameter int unsigned N_LANES = 8,
   parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   input  logic [LANE_W*N_LANES-1:0]   din,
   input  logic                        din_valid,
   input  logic [N_LANES-1:0]          tu_bitslip,
   input  logic                        slip_clr,
   output logic [LANE_W*N_LANES-1:0]   trigger_data_out,
   output logic                        trigger_valid,
   output logic [N_LANES-1:0]          lane_busy,
   output logic [SLIP_W*N_LANES-1:0]   slip_pos,
   output logic [WRAP_W-1:0]           wrap_cnt
);
   logic [N_LANES-1:0] lane_valid;
`ifdef TU_LANE_STATUS_EN
   logic [N_LANES-1:0] lane_wrap;
`endif

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      tu_lane_slip_unit #(.HOLDOFF(HOLDOFF)) u_unit (
         .clk_i       (S_AXI_ACLK),
         .rst_n_i     (S_AXI_ARESETN),
         .din_i       (din[g*LANE_W +: LANE_W]),
         .din_valid_i (din_valid),
         .slip_i      (tu_bitslip[g]),
         .slip_clr_i  (slip_clr),
         .dout_o      (trigger_data_out[g*LANE_W +: LANE_W]),
         .valid_o     (lane_valid[g]),
         .busy_o      (lane_busy[g])
`ifdef TU_LANE_STATUS_EN
         ,
         .pos_o       (slip_pos[g*SLIP_W +: SLIP_W]),
         .wrap_o      (lane_wrap[g])
`endif
      );
   end

   // every lane sees the same din_valid, so the valid bits are identical
   assign trigger_valid = &lane_valid;

`ifdef TU_LANE_STATUS_EN
   logic [WRAP_W-1:0] wrap_q, wrap_d, wrap_add;
   logic [WRAP_W:0]   wrap_sum;

   always_comb begin
      wrap_add = '0;
      for (int i = 0; i < N_LANES; i++) begin
         wrap_add = wrap_add + WRAP_W'(lane_wrap[i]);
      end
      wrap_sum = (WRAP_W+1)'(wrap_q) + (WRAP_W+1)'(wrap_add);
      wrap_d   = wrap_sum[WRAP_W] ? '1 : wrap_sum[WRAP_W-1:0];
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         wrap_q <= '0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap_cnt = wrap_q;
`else
   assign slip_pos = '0;
   assign wrap_cnt = '0;
`endif
endmodule

// File: tb/tb_tu_lane_slipper.sv
// Scoreboard bench for tu_lane_slipper: directed scenarios then randomized traffic against a reference model.
module tb_tu_lane_slipper;
   import tu_pkg::*;

   localparam int NL = 8;
   localparam int HO = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [63:0]      din = '0;
   logic             din_valid = 1'b0;
   logic [NL-1:0]    tu_bitslip = '0;
   logic             slip_clr = 1'b0;
   logic [63:0]      trigger_data_out;
   logic             trigger_valid;
   logic [NL-1:0]    lane_busy;
   logic [3*NL-1:0]  slip_pos;
   logic [15:0]      wrap_cnt;

   always #5 clk = ~clk;

   tu_lane_slipper #(.N_LANES(NL), .HOLDOFF(HO)) dut (
      .S_AXI_ACLK       (clk),
      .S_AXI_ARESETN    (rst_n),
      .din              (din),
      .din_valid        (din_valid),
      .tu_bitslip       (tu_bitslip),
      .slip_clr         (slip_clr),
      .trigger_data_out (trigger_data_out),
      .trigger_valid    (trigger_valid),
      .lane_busy        (lane_busy),
      .slip_pos         (slip_pos),
      .wrap_cnt         (wrap_cnt)
   );

   int checks = 0;
   int failures = 0;

   // reference model state: the last two accepted words, pointers, last accepted slip edge per lane
   logic [63:0] exp_q[$];
   logic [63:0] exp_hold = '0;
   logic [63:0] hist_cur, hist_prev, w;
   logic [15:0] win;
   bit          s1 = 0;
   bit          started = 0;
   int          n = 0;
   int          p_m[NL];
   int          last_m[NL];
   int          wrap_m = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      n++;
      if (!rst_n) begin
         hist_cur  = '0;
         hist_prev = '0;
         s1        = 0;
         wrap_m    = 0;
         exp_hold  = '0;
         exp_q.delete();
         for (int l = 0; l < NL; l++) begin
            p_m[l]    = 0;
            last_m[l] = -100;
         end
         started = 1;
      end else begin
         if (s1) begin
            w = '0;
            for (int l = 0; l < NL; l++) begin
               win = {hist_cur[8*l +: 8], hist_prev[8*l +: 8]};
               w[8*l +: 8] = 8'(win >> p_m[l]);
            end
            exp_q.push_back(w);
         end
         if (slip_clr) begin
            for (int l = 0; l < NL; l++) begin
               p_m[l]    = 0;
               last_m[l] = -100;
            end
         end else begin
            for (int l = 0; l < NL; l++) begin
               if (tu_bitslip[l] && (n - last_m[l]) > HO) begin
                  if (p_m[l] == 7 && wrap_m < 65535) wrap_m++;
                  p_m[l]    = (p_m[l] + 1) % 8;
                  last_m[l] = n;
               end
            end
         end
         if (din_valid) begin
            hist_prev = hist_cur;
            hist_cur  = din;
         end
         s1 = din_valid;
      end
   end

   logic [NL-1:0]   busy_e;
   logic [3*NL-1:0] pos_e;
   logic [15:0]     wrap_e;

   always @(negedge clk) begin
      if (started) begin
         chk("trigger_valid", 64'(trigger_valid), 64'(exp_q.size() > 0));
         if (exp_q.size() > 0) exp_hold = exp_q.pop_front();
         chk("trigger_data_out", trigger_data_out, exp_hold);
         for (int l = 0; l < NL; l++) begin
            busy_e[l] = (n - last_m[l]) < HO;
`ifdef TU_LANE_STATUS_EN
            pos_e[3*l +: 3] = 3'(p_m[l]);
`else
            pos_e[3*l +: 3] = 3'd0;
`endif
         end
`ifdef TU_LANE_STATUS_EN
         wrap_e = 16'(wrap_m);
`else
         wrap_e = 16'd0;
`endif
         chk("lane_busy", 64'(lane_busy), 64'(busy_e));
         chk("slip_pos", 64'(slip_pos), 64'(pos_e));
         chk("wrap_cnt", 64'(wrap_cnt), 64'(wrap_e));
      end
   end

   task automatic step(input logic [63:0] d, input logic dv, input logic [7:0] sl,
                       input logic clr, input logic rn);
      din        = d;
      din_valid  = dv;
      tu_bitslip = sl;
      slip_clr   = clr;
      rst_n      = rn;
      @(negedge clk);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   logic [63:0] dconst;
   logic [7:0]  alt;

   initial begin
      dconst = 64'h0123456789ABCDEF;
      repeat (2) step(64'h0, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (6) step(dconst, 1'b1, 8'h00, 1'b0, 1'b1);

      for (int i = 0; i < 14; i++) begin
         alt = (i % 2 == 1) ? 8'h0F : 8'hF0;
         step({dconst[63:8], alt}, 1'b1, (i == 4) ? 8'h01 : 8'h00, 1'b0, 1'b1);
      end

      for (int i = 0; i < 10; i++)
         step(rnd64(), 1'b1, (i == 0 || i == 2 || i == 5) ? 8'h08 : 8'h00, 1'b0, 1'b1);

      for (int k = 0; k < 8; k++) begin
         step(rnd64(), 1'b1, 8'h80, 1'b0, 1'b1);
         repeat (4) step(rnd64(), 1'b1, 8'h00, 1'b0, 1'b1);
      end
      for (int k = 0; k < 8; k++) begin
         step(rnd64(), 1'b1, 8'h06, 1'b0, 1'b1);
         repeat (4) step(rnd64(), 1'b1, 8'h00, 1'b0, 1'b1);
      end

      step(rnd64(), 1'b1, 8'hFF, 1'b0, 1'b1);
      repeat (5) step(rnd64(), 1'b1, 8'h00, 1'b0, 1'b1);
      step(rnd64(), 1'b1, 8'hFF, 1'b1, 1'b1);
      repeat (3) step(rnd64(), 1'b1, 8'h00, 1'b0, 1'b1);

      step(rnd64(), 1'b1, 8'hFF, 1'b0, 1'b1);
      step(rnd64(), 1'b0, 8'h00, 1'b0, 1'b1);
      step(rnd64(), 1'b1, 8'h00, 1'b0, 1'b0);
      step(rnd64(), 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
         step(rnd64(), (i % 2 == 0) ? 1'b1 : 1'b0, 8'h00, 1'b0, 1'b1);

      for (int i = 0; i < 2000; i++) begin
         step(rnd64(),
              ($urandom_range(0, 3) != 0),
              8'($urandom & $urandom),
              ($urandom_range(0, 49) == 0),
              ($urandom_range(0, 299) != 0));
      end

      repeat (4) step(64'h0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
